// File: rtl/eq_pkg.sv
// -----------------------------------------------------------------------------
// eq_pkg
// Shared types and defaults for the EQ gain controller.
//   gain_t      : signed 16-bit gain in dB
//   state_t     : issue sequencer states
//   GAIN_*_DB   : default gain limits
//   BIQUAD_SET_GAP : cycles between consecutive set strobes
//   sat_step()  : +/-1 step with saturation, computed in 17 bits
// -----------------------------------------------------------------------------
package eq_pkg;

    typedef logic signed [15:0] gain_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP
    } state_t;

    localparam int GAIN_MIN_DB    = -12;
    localparam int GAIN_MAX_DB    = 12;
    localparam int BIQUAD_SET_GAP = 4;

    // One step up or down, clamped to [gmin, gmax]. The extra bit keeps the
    // intermediate result from wrapping at the 16-bit boundaries.
    function automatic gain_t sat_step(input gain_t g, input logic up,
                                       input int gmin, input int gmax);
        logic signed [16:0] s;
        s = $signed({g[15], g}) + (up ? 17'sd1 : -17'sd1);
        if (int'(s) > gmax) begin
            return gain_t'(gmax);
        end else if (int'(s) < gmin) begin
            return gain_t'(gmin);
        end
        return gain_t'(s[15:0]);
    endfunction

endpackage

// File: rtl/eq_prio_pick.sv
// -----------------------------------------------------------------------------
// eq_prio_pick
// Combinational lowest-index picker over the dirty vector.
//   dirty_i : one bit per band, 1 = band needs a set request
//   idx_o   : lowest set index (0 when nothing is set)
//   valid_o : 1 when any bit of dirty_i is set
// -----------------------------------------------------------------------------
module eq_prio_pick #(
    parameter int N_BANDS = 5,
    parameter int BW      = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
    input  logic [N_BANDS-1:0] dirty_i,
    output logic [BW-1:0]      idx_o,
    output logic               valid_o
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N_BANDS - 1; i >= 0; i--) begin
            if (dirty_i[i]) begin
                idx_o   = BW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eq_gain_ctrl.sv
// -----------------------------------------------------------------------------
// eq_gain_ctrl
// Holds the user gain of every EQ band, applies button pulses as saturating
// +/-1 dB steps and pushes changed gains to the biquad filters one band at a
// time, spacing the set strobes so each filter finishes recomputing first.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_up / i_down  : step selected band gain (both together = ignored)
//   i_next/i_prev  : move selection with wrap (both together = ignored)
//   i_clear        : all nonzero gains to 0 (wins over i_up/i_down)
//   o_band         : selected band
//   o_band_gain    : gain of the selected band
//   o_set          : one-hot, one-cycle set strobe per filter
//   o_gain         : gain bus shared by the filters, valid with o_set
//   o_busy         : sequence in progress or any band still dirty
// -----------------------------------------------------------------------------
module eq_gain_ctrl
    import eq_pkg::*;
#(
    parameter int N_BANDS  = 5,
    parameter int GAIN_MIN = GAIN_MIN_DB,
    parameter int GAIN_MAX = GAIN_MAX_DB,
    parameter int SET_GAP  = BIQUAD_SET_GAP,
    parameter int BW       = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_up,
    input  logic               i_down,
    input  logic               i_next,
    input  logic               i_prev,
    input  logic               i_clear,
    output logic [BW-1:0]      o_band,
    output logic [15:0]        o_band_gain,
    output logic [N_BANDS-1:0] o_set,
    output logic [15:0]        o_gain,
    output logic               o_busy
);

    localparam int CW = (SET_GAP > 2) ? $clog2(SET_GAP) : 1;
    localparam logic [N_BANDS-1:0] ONE_HOT0 = N_BANDS'(1);

    gain_t               gain_q [N_BANDS];
    gain_t               gain_d [N_BANDS];
    logic [N_BANDS-1:0]  chg;
    logic [N_BANDS-1:0]  dirty_q, dirty_d;
    logic [BW-1:0]       band_q, band_d;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [BW-1:0]       issue_q;
    logic [N_BANDS-1:0]  set_q;
    gain_t               gain_out_q;

    logic [BW-1:0]       pick_idx;
    logic                pick_valid;
    logic                step_en;

    assign step_en = i_up ^ i_down;

    // -------------------------------------------------------------------------
    // Per-band next gain and change flag. A band counts as changed only when
    // its stored value really moves, so saturated presses stay silent.
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < N_BANDS; gi++) begin : g_band
        logic  sel;
        gain_t stepped;

        assign sel     = (band_q == BW'(gi));
        assign stepped = sat_step(gain_q[gi], i_up, GAIN_MIN, GAIN_MAX);

        assign chg[gi] = i_clear ? (gain_q[gi] != '0)
                                 : (step_en && sel && (stepped != gain_q[gi]));

        assign gain_d[gi] = !chg[gi] ? gain_q[gi]
                          : (i_clear ? gain_t'(0) : stepped);
    end

    // Selection moves at the same edge a gain pulse lands on the old band.
    always_comb begin
        band_d = band_q;
        if (i_next && !i_prev) begin
            band_d = (band_q == BW'(N_BANDS - 1)) ? '0 : band_q + 1'b1;
        end else if (i_prev && !i_next) begin
            band_d = (band_q == '0) ? BW'(N_BANDS - 1) : band_q - 1'b1;
        end
    end

    // The issued band is cleared at the ISSUE exit edge, but a change landing
    // on that same edge re-dirties it so the newest value is sent later.
    always_comb begin
        dirty_d = dirty_q;
        if (state_q == S_ISSUE) begin
            dirty_d[issue_q] = 1'b0;
        end
        dirty_d = dirty_d | chg;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_BANDS; i++) begin
                gain_q[i] <= '0;
            end
            dirty_q <= '0;
            band_q  <= '0;
        end else begin
            for (int i = 0; i < N_BANDS; i++) begin
                gain_q[i] <= gain_d[i];
            end
            dirty_q <= dirty_d;
            band_q  <= band_d;
        end
    end

    eq_prio_pick #(
        .N_BANDS (N_BANDS),
        .BW      (BW)
    ) u_pick (
        .dirty_i (dirty_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // -------------------------------------------------------------------------
    // Issue sequencer. o_set/o_gain are loaded on the edge entering S_ISSUE,
    // using gain_d so the bus carries the value the band holds during the
    // strobe cycle even if it was stepped on that very edge.
    // The gap counter leaves S_GAP on the edge where it would reach zero, so
    // strobes are SET_GAP cycles apart (ISSUE + GAP cycles + one IDLE).
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            issue_q    <= '0;
            set_q      <= '0;
            gain_out_q <= '0;
        end else begin
            set_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        state_q    <= S_ISSUE;
                        issue_q    <= pick_idx;
                        set_q      <= ONE_HOT0 << pick_idx;
                        gain_out_q <= gain_d[pick_idx];
                    end
                end
                S_ISSUE: begin
                    state_q <= S_GAP;
                    cnt_q   <= CW'(SET_GAP - 2);
                end
                S_GAP: begin
                    if (cnt_q <= CW'(1)) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_band      = band_q;
    assign o_band_gain = gain_q[band_q];
    assign o_set       = set_q;
    assign o_gain      = gain_out_q;
    assign o_busy      = (state_q != S_IDLE) | (|dirty_q);

endmodule
